ram_data_mc: RTL and testbench

Multi-port, parametrised data memory shared by NCORES processor cores. A single synchronous memory array sits behind a round-robin arbiter that grants one core access per cycle. Each grant performs either a 16-bit-lane-masked write or a registered read. The block replaces the single-requester data RAM in the multicore build and adds reset, a request/acknowledge handshake, per-lane write strobes and out-of-range detection.

---
 rtl/ram_data_mc.sv | 86 ++++++++
 tb/tb_ram_data_mc.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ram_data_mc.sv
// ram_data_mc: NCORES-port data RAM behind a round-robin arbiter, one access per cycle
// Ports: clk, rst_n (async, active-low); per-core REQ/WR/BE/ADDBUS/DATAIN in;
//        ACK (combinational one-hot grant), RVALID/ERR (registered one-hot pulses),
//        DATAOUT (shared registered read data, holds when RVALID=0).
module ram_data_mc #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 512,
   parameter int NCORES = 4,
   localparam int LANES = DATA_W / 16,
   localparam int PW    = NCORES > 1 ? $clog2(NCORES) : 1,
   localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NCORES-1:0]          REQ,
   input  logic [NCORES-1:0]          WR,
   input  logic [NCORES*LANES-1:0]    BE,
   input  logic [NCORES*ADDR_W-1:0]   ADDBUS,
   input  logic [NCORES*DATA_W-1:0]   DATAIN,
   output logic [NCORES-1:0]          ACK,
   output logic [NCORES-1:0]          RVALID,
   output logic [DATA_W-1:0]          DATAOUT,
   output logic [NCORES-1:0]          ERR
);
   // words 0..3: matrix A rows {n,n+1,n+2,n+3}; words 4..7: matrix B = identity
   logic [DATA_W-1:0] mem [DEPTH] = '{
      0: DATA_W'(64'h0000_0001_0002_0003),
      1: DATA_W'(64'h0001_0002_0003_0004),
      2: DATA_W'(64'h0002_0003_0004_0005),
      3: DATA_W'(64'h0003_0004_0005_0006),
      4: DATA_W'(64'h0001_0000_0000_0000),
      5: DATA_W'(64'h0000_0001_0000_0000),
      6: DATA_W'(64'h0000_0000_0001_0000),
      7: DATA_W'(64'h0000_0000_0000_0001),
      default: '0
   };
   logic [PW-1:0]     ptr, win;
   logic              any, gnt, wr, oor;
   logic [ADDR_W-1:0] a;
   logic [LANES-1:0]  be;
   logic [DATA_W-1:0] din;

   // scan downward from ptr+NCORES-1 so the last hit is the one closest to ptr
   always_comb begin
      win = '0;
      any = 1'b0;
      for (int j = NCORES - 1; j >= 0; j--)
         if (REQ[(int'(ptr) + j) % NCORES]) begin
            win = PW'((int'(ptr) + j) % NCORES);
            any = 1'b1;
         end
      gnt = any & rst_n;
      ACK = gnt ? NCORES'(1) << win : '0;
      wr  = WR[win];
      a   = ADDBUS[win*ADDR_W +: ADDR_W];
      be  = BE[win*LANES +: LANES];
      din = DATAIN[win*DATA_W +: DATA_W];
      oor = {1'b0, a} >= (ADDR_W+1)'(DEPTH);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ptr     <= '0;
         RVALID  <= '0;
         ERR     <= '0;
         DATAOUT <= '0;
      end else begin
         RVALID <= '0;
         ERR    <= '0;
         if (gnt) begin
            ptr <= win == PW'(NCORES - 1) ? '0 : win + 1'b1;
            ERR <= oor ? ACK : '0;
            if (!wr) begin
               RVALID  <= ACK;
               DATAOUT <= oor ? '0 : mem[a[AW-1:0]];
            end
         end
      end

   // the array has no reset: contents survive rst_n
   always_ff @(posedge clk)
      if (gnt && wr && !oor)
         for (int k = 0; k < LANES; k++)
            if (be[k]) mem[a[AW-1:0]][16*k +: 16] <= din[16*k +: 16];
endmodule

// File: tb/tb_ram_data_mc.sv
// tb_ram_data_mc: scoreboard bench for ram_data_mc, directed vectors
module tb_ram_data_mc;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    req = '0, wr = '0;
   logic [15:0]   be = '0;
   logic [63:0]   addbus = '0;
   logic [255:0]  datain = '0;
   logic [3:0]    ack, rvalid, err;
   logic [63:0]   dataout;
   int            vectors = 0, miscompares = 0;

   typedef struct {
      logic [3:0]  rv;
      logic [3:0]  er;
      logic [63:0] data;
      logic        chk;
   } exp_t;
   exp_t q[$];

   ram_data_mc dut (
      .clk(clk), .rst_n(rst_n), .REQ(req), .WR(wr), .BE(be), .ADDBUS(addbus),
      .DATAIN(datain), .ACK(ack), .RVALID(rvalid), .DATAOUT(dataout), .ERR(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_out(input int c, input logic w, input logic [15:0] a, input logic [63:0] d);
      exp_t e;
      logic o;
      o = a >= 16'd512;
      e.rv   = w ? 4'b0 : 4'(1 << c);
      e.er   = o ? 4'(1 << c) : 4'b0;
      e.data = o ? 64'h0 : d;
      e.chk  = !w;
      if (!w || o) q.push_back(e);
   endtask

   task automatic set_core(input int c, input logic w, input logic [3:0] b, input logic [15:0] a, input logic [63:0] d);
      req[c] = 1'b1;
      wr[c] = w;
      be[c*4 +: 4] = b;
      addbus[c*16 +: 16] = a;
      datain[c*64 +: 64] = d;
   endtask

   // d is write data for writes, expected read data for reads
   task automatic access(input int c, input logic w, input logic [3:0] b, input logic [15:0] a, input logic [63:0] d);
      int n;
      @(negedge clk);
      req = '0;
      set_core(c, w, b, a, d);
      #1;
      n = 0;
      while (!ack[c] && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("ack", 64'(ack), 64'(1 << c));
      expect_out(c, w, a, d);
      @(posedge clk);
      #1 req = '0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (|rvalid || |err) begin
            if (q.size() == 0) check("unexpected_out", {56'h0, rvalid, err}, 64'h0);
            else begin
               e = q.pop_front();
               check("rvalid", 64'(rvalid), 64'(e.rv));
               check("err", 64'(err), 64'(e.er));
               if (e.chk) check("dataout", dataout, e.data);
            end
         end
      end
   end

   initial begin : stim
      logic [3:0] seq [4];
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
      req = 4'b1111;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ack", 64'(ack), 64'h0);
      check("rst_rvalid", 64'(rvalid), 64'h0);
      check("rst_err", 64'(err), 64'h0);
      check("rst_dataout", dataout, 64'h0);
      req = '0;
      rst_n = 1'b1;
      // full contention with no-op writes
      @(negedge clk);
      for (int c = 0; c < 4; c++) set_core(c, 1'b1, 4'b0, 16'(c), 64'hDEAD);
      for (int i = 0; i < 8; i++) begin
         #1 check("contention_ack", 64'(ack), 64'(seq[i % 4]));
         @(negedge clk);
      end
      req = '0;
      access(0, 1'b0, 4'b0, 16'd1, 64'h0001_0002_0003_0004);
      // ptr=1, only cores 0 and 3 requesting
      @(negedge clk);
      set_core(3, 1'b0, 4'b0, 16'd2, 64'h0);
      set_core(0, 1'b0, 4'b0, 16'd5, 64'h0);
      #1 check("skip_ack3", 64'(ack), 64'b1000);
      expect_out(3, 1'b0, 16'd2, 64'h0002_0003_0004_0005);
      @(posedge clk);
      #1 req[3] = 1'b0;
      @(negedge clk);
      #1 check("skip_ack0", 64'(ack), 64'b0001);
      expect_out(0, 1'b0, 16'd5, 64'h0000_0001_0000_0000);
      @(posedge clk);
      #1 req = '0;
      @(negedge clk);
      for (int c = 0; c < 4; c++) set_core(c, 1'b1, 4'b0, 16'd20, 64'hDEAD);
      #1 check("ptr_after_skip", 64'(ack), 64'b0010);
      @(posedge clk);
      #1 req = '0;
      // lane-masked write
      access(2, 1'b1, 4'b1111, 16'd10, 64'h1111_2222_3333_4444);
      access(2, 1'b1, 4'b0101, 16'd10, 64'hAAAA_BBBB_CCCC_DDDD);
      access(2, 1'b0, 4'b0, 16'd10, 64'h1111_BBBB_3333_DDDD);
      access(2, 1'b1, 4'b0000, 16'd10, 64'h5555_5555_5555_5555);
      access(2, 1'b0, 4'b0, 16'd10, 64'h1111_BBBB_3333_DDDD);
      // out of range
      access(1, 1'b0, 4'b0, 16'd600, 64'h0);
      access(1, 1'b1, 4'b1111, 16'd512, 64'hFFFF_FFFF_FFFF_FFFF);
      access(1, 1'b0, 4'b0, 16'd0, 64'h0000_0001_0002_0003);
      access(1, 1'b0, 4'b0, 16'd511, 64'h0);
      access(3, 1'b0, 4'b0, 16'd7, 64'h0000_0000_0000_0001);
      // reset in the cycle after a read grant
      @(negedge clk);
      req = '0;
      set_core(0, 1'b0, 4'b0, 16'd3, 64'h0);
      #1 check("mid_ack", 64'(ack), 64'b0001);
      @(posedge clk);
      #1 rst_n = 1'b0;
      req = '0;
      @(negedge clk);
      check("mid_rvalid", 64'(rvalid), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      access(0, 1'b0, 4'b0, 16'd3, 64'h0003_0004_0005_0006);
      repeat (3) @(negedge clk);
      check("drain", 64'(q.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
